// File: rtl/stim_gen_pkg.sv
// Shared types for the stim_gen stimulus generator: FSM state encoding and default counter width.
// Pure declarations, no logic.
package stim_gen_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/stim_toggle.sv
// Half-period counter plus toggle flop; output flips after i_half enabled cycles, then the count wraps.
// Output registered; i_clr has priority over i_en; i_half must be nonzero.
module stim_toggle
  import stim_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_half,
  output logic             o_q
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic             r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (i_en) begin
      if (r_cnt == i_half - ONE) begin
        r_cnt <= '0;
        r_q   <= ~r_q;
      end else begin
        r_cnt <= r_cnt + ONE;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/stim_gen.sv
// Two-tone stimulus generator for an AND-gate UUT; optional y-vs-(a&b) checker under STIM_GEN_CHECK_EN.
// All outputs registered; start accepted only in IDLE, abort ends RUN on the next edge.
module stim_gen
  import stim_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] half_a,
  input  logic [CNT_W-1:0] half_b,
  input  logic [CNT_W-1:0] n_cycles,
  output logic             a,
  output logic             b,
  output logic             busy,
`ifdef STIM_GEN_CHECK_EN
  input  logic             y,
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_nxt_state;
  logic [CNT_W-1:0] r_half_a;
  logic [CNT_W-1:0] r_half_b;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_run_cnt;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_last;
  logic             w_tog_en;
  logic             w_tog_clr;

  assign w_accept  = (r_state == ST_IDLE) && start && !abort;
  assign w_last    = (r_state == ST_RUN) && (abort || (r_run_cnt == r_len - ONE));
  // The final RUN cycle must not toggle, so a/b hold their last RUN value through DONE.
  assign w_tog_en  = (r_state == ST_RUN) && !w_last;
  assign w_tog_clr = w_accept || (r_state == ST_DONE);

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_nxt_state = ST_RUN;
      ST_RUN:  if (w_last)   w_nxt_state = ST_DONE;
      ST_DONE: w_nxt_state = ST_IDLE;
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_half_a  <= '0;
      r_half_b  <= '0;
      r_len     <= '0;
      r_run_cnt <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_busy  <= (w_nxt_state == ST_RUN);
      r_done  <= (w_nxt_state == ST_DONE);
      if (w_accept) begin
        // Zero half-periods and a zero run length behave as 1.
        r_half_a  <= (half_a == '0) ? ONE : half_a;
        r_half_b  <= (half_b == '0) ? ONE : half_b;
        r_len     <= (n_cycles == '0) ? ONE : n_cycles;
        r_run_cnt <= '0;
      end else if (w_tog_en) begin
        r_run_cnt <= r_run_cnt + ONE;
      end
    end
  end

  stim_toggle #(.CNT_W(CNT_W)) u_tog_a (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (w_tog_en),
    .i_clr  (w_tog_clr),
    .i_half (r_half_a),
    .o_q    (a)
  );

  stim_toggle #(.CNT_W(CNT_W)) u_tog_b (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (w_tog_en),
    .i_clr  (w_tog_clr),
    .i_half (r_half_b),
    .o_q    (b)
  );

  assign busy = r_busy;
  assign done = r_done;

`ifdef STIM_GEN_CHECK_EN
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_accept) begin
      r_err_cnt <= '0;
    end else if ((r_state == ST_RUN) && (y != (a & b)) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ONE;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_stim_gen.sv
// Scoreboard bench for stim_gen: a reference model expands each run into a per-cycle expected trace,
// and a negedge monitor pops and compares it against a, b, busy, done (and err_cnt when checking is built in).
module tb_stim_gen;

  typedef struct packed {
    logic        a;
    logic        b;
    logic        busy;
    logic        done;
    logic        chk_err;
    logic [15:0] err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] half_a = '0;
  logic [15:0] half_b = '0;
  logic [15:0] n_cycles = '0;
  logic        a, b, busy, done;
`ifdef STIM_GEN_CHECK_EN
  logic        y;
  logic [15:0] err_cnt;
  logic        y_or = 1'b0;
  int          last_err = 0;
  assign y = y_or ? (a | b) : (a & b);
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t scb[$];

  always #5 clk = ~clk;

  stim_gen #(.CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .half_a   (half_a),
    .half_b   (half_b),
    .n_cycles (n_cycles),
    .a        (a),
    .b        (b),
    .busy     (busy),
`ifdef STIM_GEN_CHECK_EN
    .y        (y),
    .err_cnt  (err_cnt),
`endif
    .done     (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected sample per cycle; an empty queue means the block must be idle.
  always @(negedge clk) begin
    exp_t e;
    if (scb.size() > 0) e = scb.pop_front();
    else e = '0;
    chk("abBusyDone", {28'd0, a, b, busy, done}, {28'd0, e.a, e.b, e.busy, e.done});
`ifdef STIM_GEN_CHECK_EN
    if (e.chk_err) chk("err_cnt", {16'd0, err_cnt}, {16'd0, e.err});
`endif
  end

  function automatic logic wave(input int k, input int h);
    return ((k / h) % 2) == 1;
  endfunction

  // Drives one run from IDLE and pushes its full trace: pre-accept idle, L RUN cycles, DONE, trailing idle.
  task automatic run(input int ha_in, input int hb_in, input int n_in, input int abort_at,
                     input bit ymode, input bit noisy);
    int   ha, hb, len, tot;
    exp_t e;
    ha  = (ha_in == 0) ? 1 : ha_in;
    hb  = (hb_in == 0) ? 1 : hb_in;
    len = (n_in == 0) ? 1 : n_in;
    if (abort_at >= 0 && abort_at < len) len = abort_at + 1;
    tot = 0;
    e = '0;
    scb.push_back(e);
    for (int k = 0; k < len; k++) begin
      e = '0;
      e.a = wave(k, ha);
      e.b = wave(k, hb);
      e.busy = 1'b1;
      if (ymode && (e.a != e.b)) tot++;
      scb.push_back(e);
    end
    e = '0;
    e.a = wave(len - 1, ha);
    e.b = wave(len - 1, hb);
    e.done = 1'b1;
    e.chk_err = 1'b1;
    e.err = 16'(tot);
    scb.push_back(e);
    e = '0;
    e.chk_err = 1'b1;
    e.err = 16'(tot);
    scb.push_back(e);

`ifdef STIM_GEN_CHECK_EN
    y_or = ymode;
`endif
    half_a = 16'(ha_in);
    half_b = 16'(hb_in);
    n_cycles = 16'(n_in);
    abort = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < len; k++) begin
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) begin
        half_a = 16'($urandom_range(0, 65535));
        half_b = 16'($urandom_range(0, 65535));
        n_cycles = 16'($urandom_range(0, 65535));
      end
      abort = (k == abort_at);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = noisy ? 1'b1 : 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
`ifdef STIM_GEN_CHECK_EN
    last_err = tot;
`endif
  endtask

  task automatic reset_mid_run();
    exp_t e;
    e = '0;
    scb.push_back(e);
    for (int k = 0; k <= 12; k++) begin
      e = '0;
      e.a = wave(k, 5);
      e.b = wave(k, 10);
      e.busy = 1'b1;
      scb.push_back(e);
    end
    half_a = 16'd5;
    half_b = 16'd10;
    n_cycles = 16'd100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outs", {28'd0, a, b, busy, done}, 32'd0);
`ifdef STIM_GEN_CHECK_EN
    chk("rst_async_err", {16'd0, err_cnt}, 32'd0);
    last_err = 0;
`endif
    scb.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("reset_outs", {28'd0, a, b, busy, done}, 32'd0);
`ifdef STIM_GEN_CHECK_EN
    chk("reset_err", {16'd0, err_cnt}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    run(5, 10, 40, -1, 1'b1, 1'b0);
    run(5, 10, 40, -1, 1'b0, 1'b1);
    run(0, 1, 4, -1, 1'b0, 1'b0);
    run(3, 4, 100, 7, 1'b1, 1'b1);
    run(2, 3, 0, -1, 1'b1, 1'b0);
    reset_mid_run();
    run(5, 10, 40, -1, 1'b1, 1'b0);

    // start together with abort in IDLE must be refused and leave err_cnt alone.
    half_a = 16'd2;
    half_b = 16'd3;
    n_cycles = 16'd9;
    start = 1'b1;
    abort = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("start_abort_idle_busy", {31'd0, busy}, 32'd0);
`ifdef STIM_GEN_CHECK_EN
    chk("start_abort_idle_err", {16'd0, err_cnt}, 32'(last_err));
`endif
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 25; i++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
      run(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 30)),
          ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("scb_drained", 32'(scb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stim_gen.md
STIM_GEN -- requirements
Module: stim_gen

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of all counters and configuration inputs.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin a run; accepted only in IDLE.
REQ-005 abort  input  1  synchronous request to end a run early.
REQ-006 half_a  input  CNT_W  half-period of output a, in clk cycles.
REQ-007 half_b  input  CNT_W  half-period of output b, in clk cycles.
REQ-008 n_cycles  input  CNT_W  run length, in clk cycles.
REQ-009 a  output  1  stimulus A to the downstream AND-gate unit under test.
REQ-010 b  output  1  stimulus B to the downstream AND-gate unit under test.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse when a run ends.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE -> RUN when start=1 and abort=0; on that edge, half_a, half_b and n_cycles SHALL be latched, and later input changes SHALL be ignored.
REQ-015 A latched half value of 0 SHALL be treated as 1.
REQ-016 a and b SHALL be 0 in IDLE and on the first RUN cycle.
REQ-017 a SHALL toggle every half_a RUN cycles: first toggle at RUN cycle half_a, counting the entry cycle as cycle 0.
REQ-018 b SHALL toggle every half_b RUN cycles under the same counting rule.
REQ-019 The toggle counters SHALL wrap to 0 on each toggle.
REQ-020 RUN -> DONE after exactly n_cycles RUN cycles.
REQ-021 n_cycles=0 SHALL give exactly one RUN cycle with no toggles.
REQ-022 RUN -> DONE on the next edge when abort=1; abort SHALL take priority over the run-length count.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE with a=b=0.
REQ-024 start while in RUN or DONE SHALL be ignored, with no queuing.
REQ-025 start=1 together with abort=1 in IDLE SHALL keep the FSM in IDLE.
REQ-026 busy SHALL equal (state==RUN).
REQ-027 All outputs SHALL be registered, with no combinational input-to-output paths.

Reset
REQ-028 rst SHALL immediately force IDLE, a=0, b=0, busy=0, done=0, all counters 0 and err_cnt=0, independent of clk.
REQ-029 Reset asserted mid-run SHALL discard the run and SHALL NOT produce a done pulse.

Configuration
REQ-030 With STIM_GEN_CHECK_EN defined, the block SHALL add the following self-check ports:
- y  input  1: the unit-under-test output.
- err_cnt  output  CNT_W: mismatch count.
REQ-031 Under STIM_GEN_CHECK_EN, each RUN cycle SHALL compare y against (a & b) of the same cycle, and each mismatch SHALL increment err_cnt.
REQ-032 err_cnt SHALL saturate at all-ones, SHALL clear on start acceptance, and SHALL hold its value through DONE and IDLE.
REQ-033 Without STIM_GEN_CHECK_EN, the y and err_cnt ports and the checking logic SHALL be absent, and the behaviour of a, b, busy and done SHALL be identical to the checked build.

Structure
REQ-034 Package stim_gen_pkg SHALL hold:
- the FSM state enum (IDLE, RUN, DONE);
- the default CNT_W constant.
REQ-035 Sub-module stim_toggle SHALL implement one half-period counter plus toggle flop, with an enable and synchronous clear, and SHALL be instantiated twice (for a and b).

Verification
REQ-036 half_a=5, half_b=10, n_cycles=40:
- a toggles at RUN cycles 5, 10, …, 35;
- b toggles at cycles 10, 20, 30;
- busy is high for 40 cycles, then done pulses once.
REQ-037 half_a=0, half_b=1, n_cycles=4: a and b both toggle every cycle; done follows after 4 cycles.
REQ-038 n_cycles=100 with abort pulsed at RUN cycle 7: DONE on the next edge, done pulses once, a=b=0 afterwards.
REQ-039 rst asserted at RUN cycle 12:
- outputs are 0 asynchronously;
- no done pulse occurs;
- a following start runs normally.
REQ-040 start re-pulsed during RUN and during DONE is ignored; start with abort in IDLE stays in IDLE.
REQ-041 Under STIM_GEN_CHECK_EN, with y tied to a|b, half_a=5, half_b=10, n_cycles=40: err_cnt=20 at done; a correct AND unit under test gives err_cnt=0.
